// File: rtl/rle_stream_loader.sv
// rle_stream_loader
//   Loads one solver frame from a run-length-encoded word stream. Each
//   accepted word is expanded into a bit FIFO. Header fields and payload
//   values are then read from the FIFO head, MSB first, one field per cycle.
//   Every field that has a RAM home is written through a single shared
//   write port, one cycle after it is consumed.
//
// Handshake: a word transfers on a rising clk edge where in_valid && in_ready.
//   in_data/in_last must hold while in_valid is high and in_ready is low.
//   in_ready never depends on in_valid.
//
// Ports
//   clk, rst (async, active-low)
//   start                       : begin a frame (ignored unless idle)
//   in_valid/in_ready/in_data/in_last : encoded word stream
//   wr_en/wr_ch/wr_addr/wr_data : RAM write port (ch0 = A, ch1 = B, ch3 = scalars)
//   mode, fixed_point, iter_count : registered header fields
//   busy, done (1-cycle pulse), error (sticky underrun flag)
//   state_dbg                   : current FSM state, for observation only
module rle_stream_loader #(
  parameter int WORD_W = 32,
  parameter int RUN_W  = 3,
  parameter int BUF_W  = 128,
  parameter int DIM_W  = 6,
  parameter int VAL_W  = 16,
  parameter int DATA_W = 64,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_last,
  output logic              wr_en,
  output logic [1:0]        wr_ch,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              mode,
  output logic [1:0]        fixed_point,
  output logic [3:0]        iter_count,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [3:0]        state_dbg
);

  localparam int SYMS   = WORD_W / (RUN_W + 1);
  localparam int MAXRUN = SYMS * ((1 << RUN_W) - 1);
  localparam int CNT_W  = $clog2(BUF_W + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_N, S_M, S_MODE, S_H, S_ERR, S_FP, S_CNT,
    S_PAY_A, S_PAY_B, S_DONE, S_FAIL
  } state_t;

  state_t state_q, state_d;

  // The FIFO is kept LSB-aligned: the cnt_q valid bits sit in buf_q[cnt_q-1:0]
  // with the oldest bit at the top. Consuming a field only lowers cnt_q; bits
  // above the count are stale and are masked off on extraction.
  logic [BUF_W-1:0]  buf_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              last_seen_q;
  logic [DIM_W-1:0]  idx_q;
  logic [DIM_W-1:0]  n_q;
  logic [DIM_W-1:0]  m_q;

  logic [MAXRUN-1:0] exp_bits;
  logic [CNT_W-1:0]  exp_len;
  logic [CNT_W-1:0]  fw;
  logic              is_field;
  logic              take;
  logic              accept;
  logic              start_ok;
  logic              last_elem;
  logic [VAL_W-1:0]  field;
  logic [DATA_W-1:0] field_sext;

  assign state_dbg = state_q;
  assign start_ok  = (state_q == S_IDLE) && start;
  assign in_ready  = busy && !last_seen_q &&
                     ((CNT_W'(BUF_W) - cnt_q) >= CNT_W'(MAXRUN));
  assign accept    = in_valid && in_ready;

  // Expand all symbols of the presented word into one right-aligned run of
  // exp_len bits; symbol 0 ends up most significant.
  always_comb begin
    logic [RUN_W:0] sym;
    exp_bits = '0;
    exp_len  = '0;
    sym      = '0;
    for (int s = 0; s < SYMS; s++) begin
      sym      = in_data[WORD_W-1-s*(RUN_W+1) -: RUN_W+1];
      exp_bits = (exp_bits << sym[RUN_W-1:0]) |
                 (sym[RUN_W] ? ((MAXRUN'(1) << sym[RUN_W-1:0]) - MAXRUN'(1))
                             : '0);
      exp_len  = exp_len + CNT_W'(sym[RUN_W-1:0]);
    end
  end

  // Width of the field the current state wants.
  always_comb begin
    fw       = '0;
    is_field = 1'b1;
    case (state_q)
      S_N, S_M:                   fw = CNT_W'(DIM_W);
      S_MODE:                     fw = CNT_W'(1);
      S_H, S_ERR, S_PAY_A, S_PAY_B: fw = CNT_W'(VAL_W);
      S_FP:                       fw = CNT_W'(2);
      S_CNT:                      fw = CNT_W'(4);
      default:                    is_field = 1'b0;
    endcase
  end

  assign take  = is_field && (cnt_q >= fw);
  assign field = VAL_W'(buf_q >> (cnt_q - fw)) &
                 ((VAL_W'(1) << fw) - VAL_W'(1));
  assign field_sext = {{(DATA_W-VAL_W){field[VAL_W-1]}}, field};
  assign last_elem  = (state_q == S_PAY_A) ? (idx_q == n_q - DIM_W'(1))
                                           : (idx_q == m_q - DIM_W'(1));

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_N;
      S_N:     if (take) state_d = S_M;
      S_M:     if (take) state_d = S_MODE;
      S_MODE:  if (take) state_d = S_H;
      S_H:     if (take) state_d = S_ERR;
      S_ERR:   if (take) state_d = S_FP;
      S_FP:    if (take) state_d = S_CNT;
      S_CNT:   if (take) state_d = (n_q != '0) ? S_PAY_A :
                                   (m_q != '0) ? S_PAY_B : S_DONE;
      S_PAY_A: if (take && last_elem) state_d = (m_q != '0) ? S_PAY_B : S_DONE;
      S_PAY_B: if (take && last_elem) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      S_FAIL:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // No more words can arrive, so a field that cannot be filled now never will.
    if (is_field && !take && last_seen_q) state_d = S_FAIL;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Datapath, FIFO and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_q       <= '0;
      cnt_q       <= '0;
      last_seen_q <= 1'b0;
      idx_q       <= '0;
      n_q         <= '0;
      m_q         <= '0;
      wr_en       <= 1'b0;
      wr_ch       <= '0;
      wr_addr     <= '0;
      wr_data     <= '0;
      mode        <= 1'b0;
      fixed_point <= '0;
      iter_count  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      done  <= (state_d == S_DONE);

      if (start_ok) begin
        busy  <= 1'b1;
        error <= 1'b0;
      end else if (state_d == S_DONE || state_d == S_FAIL) begin
        busy <= 1'b0;
        if (state_d == S_FAIL) error <= 1'b1;
      end

      if (start_ok)                 last_seen_q <= 1'b0;
      else if (accept && in_last)   last_seen_q <= 1'b1;

      if (accept) buf_q <= (buf_q << exp_len) | BUF_W'(exp_bits);

      // DONE flushes whatever surplus bits remain.
      if (start_ok || state_q == S_DONE)
        cnt_q <= '0;
      else
        cnt_q <= cnt_q + (accept ? exp_len : '0) - (take ? fw : '0);

      if (start_ok) idx_q <= '0;

      if (take) begin
        case (state_q)
          S_N: begin
            n_q     <= field[DIM_W-1:0];
            wr_en   <= 1'b1;
            wr_ch   <= 2'd0;
            wr_addr <= '0;
            wr_data <= DATA_W'(field[DIM_W-1:0]);
          end
          S_M: begin
            m_q     <= field[DIM_W-1:0];
            wr_en   <= 1'b1;
            wr_ch   <= 2'd1;
            wr_addr <= '0;
            wr_data <= DATA_W'(field[DIM_W-1:0]);
          end
          S_MODE: mode <= field[0];
          S_H, S_ERR: begin
            wr_en   <= 1'b1;
            wr_ch   <= 2'd3;
            wr_addr <= (state_q == S_ERR) ? ADDR_W'(1) : '0;
            wr_data <= field_sext;
          end
          S_FP:  fixed_point <= field[1:0];
          S_CNT: iter_count  <= field[3:0];
          S_PAY_A, S_PAY_B: begin
            wr_en   <= 1'b1;
            wr_ch   <= (state_q == S_PAY_A) ? 2'd0 : 2'd1;
            wr_addr <= ADDR_W'(idx_q) + ADDR_W'(1);
            wr_data <= field_sext;
            idx_q   <= last_elem ? '0 : idx_q + DIM_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/rle_stream_loader.md
Name: rle_stream_loader

Overview:
- Parametrised successor to the solver's IO loader.
- Accepts a stream of run-length-encoded words over a valid/ready handshake and expands each word into a bit FIFO.
- Parses the solver header (N, M, mode, h, err, fixed-point format, iteration count) and then N + M sign-extended payload values.
- Commits every field through one shared RAM write port addressed by channel, one write per cycle, so the input can stall and the frame can span any number of words.

Parameters:
- WORD_W, 32: input word width; must be a multiple of RUN_W+1.
- RUN_W, 3: run-length field width per symbol.
- BUF_W, 128: bit FIFO depth; must be at least MAXRUN + VAL_W.
- DIM_W, 6: width of the N and M fields.
- VAL_W, 16: width of the h, err and payload value fields.
- DATA_W, 64: RAM word width.
- ADDR_W, 8: RAM address width; must satisfy 2^ADDR_W > 2^DIM_W.

Ports:
- clk, input, 1: clock, all flops on the rising edge.
- rst, input, 1: asynchronous reset, active-low.
- start, input, 1: one-cycle pulse that begins a frame load; ignored while busy.
- in_valid, input, 1: in_data is valid.
- in_ready, output, 1: the loader can accept in_data this cycle.
- in_data, input, WORD_W: encoded word.
- in_last, input, 1: marks the final word of the frame; qualified by the handshake.
- wr_en, output, 1: RAM write strobe, one cycle per field.
- wr_ch, output, 2: target RAM channel (0 = A vector, 1 = B vector, 3 = scalars; 2 is reserved and never driven).
- wr_addr, output, ADDR_W: RAM address.
- wr_data, output, DATA_W: RAM data.
- mode, output, 1: registered mode bit.
- fixed_point, output, 2: registered fixed-point format.
- iter_count, output, 4: registered iteration count.
- busy, output, 1: a frame is in progress.
- done, output, 1: one-cycle pulse when the frame completes cleanly.
- error, output, 1: sticky; stream ended before the frame was complete.

Behaviour:
- Reset (rst low, asynchronous): all outputs 0, FIFO count 0, state IDLE, last_seen 0.
- Symbol format:
  - A word holds S = WORD_W/(RUN_W+1) symbols; symbol 0 is the most significant.
  - Each symbol is {bit, run}: the bit is replicated run times (run = 0 adds nothing).
  - Decoded bits enter the FIFO in symbol order; fields are read MSB-first from the FIFO head.
- MAXRUN = S*(2^RUN_W-1), which is 56 at the defaults.
- in_ready = busy & !last_seen & (BUF_W - cnt >= MAXRUN). A word is accepted when in_valid & in_ready; the whole word is expanded in the same cycle.
- Field extraction:
  - Takes one field per cycle, and only when cnt >= the current field width.
  - Accepting a word and extracting a field in the same cycle are allowed: cnt_next = cnt + added - consumed.
- States and field widths, in order: IDLE; N (DIM_W); M (DIM_W); MODE (1); H (VAL_W); ERR (VAL_W); FP (2); CNT (4); PAY_A (VAL_W x N); PAY_B (VAL_W x M); DONE; FAIL.
- IDLE -> N on start. start also clears the FIFO, last_seen, error and the payload index, and sets busy.
- Writes, each a one-cycle wr_en in the cycle after the field is consumed (latency 1):
  - N: ch0, addr 0, zero-extended.
  - M: ch1, addr 0, zero-extended.
  - H: ch3, addr 0, sign-extended from VAL_W.
  - ERR: ch3, addr 1, sign-extended from VAL_W.
  - PAY_A element k (k = 0..N-1): ch0, addr k+1, sign-extended.
  - PAY_B element k (k = 0..M-1): ch1, addr k+1, sign-extended.
- MODE, FP and CNT produce no write; they load mode, fixed_point and iter_count respectively.
- N = 0 skips PAY_A; M = 0 skips PAY_B.
- DONE: done pulses for 1 cycle, busy drops, the FIFO is flushed (surplus bits discarded), and the state returns to IDLE.
- Completion before in_last is seen: in_ready drops with busy, and later words are not accepted.
- Underrun: if last_seen = 1 and cnt < the current field width, go to FAIL. FAIL sets error, clears busy, produces no further writes, and goes to IDLE the next cycle. error holds until the next start or reset.
- An asynchronous reset mid-frame abandons the frame immediately; no further writes are issued.

Test Plan:
- Minimal frame (N = 0, M = 0), header split across two words, 51 header bits: expect writes (ch0,0,0), (ch1,0,0), (ch3,0,sext h), (ch3,1,sext err); mode, fixed_point and iter_count match; done pulses 1 cycle; no payload writes.
- First word 0x4A00_0000 encodes N = 3 (symbols {0,4},{1,2}); full frame with M = 2, A = {0x0001, 0xFFFF, 0x7FFF}, B = {0x8000, 0x0010}: expect ch0 addr1..3 = 0x1, 0xFFFF_FFFF_FFFF_FFFF, 0x7FFF; ch1 addr1..2 = 0xFFFF_FFFF_FFFF_8000, 0x10.
- Run-heavy words (all symbols 0xF, 56 bits each) with in_valid held high: in_ready drops whenever BUF_W - cnt < 56, no bits are lost, and the write sequence is identical to a gapped feed.
- Stream ends with in_last after only 20 header bits: expect error = 1, busy = 0, no done, and no writes beyond N and M.
- rst low in the middle of PAY_A: all outputs go to 0 immediately; a new start then reloads a complete frame correctly.
- start pulsed while busy is ignored; surplus bits after the last B value are discarded; a following start begins cleanly with cnt = 0.
